// File: rtl/exe_stage_pipe.sv
// Execute stage: N-source operand forwarding, valid/ready EXE/MEM output register,
// flush, and an iterative MUL/MLA unit retiring MUL_BPC multiplier bits per cycle.

module exe_val2gen (
   input  logic [31:0] val_rm,
   input  logic        imm,
   input  logic [11:0] shift_operand,
   input  logic        mem_en,
   output logic [31:0] val2
);
   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
      return (x >> n) | (x << (6'd32 - {1'b0, n}));
   endfunction

   // Second operand: memory offset, rotated 8-bit immediate, or shifted Rm
   always_comb begin
      val2 = 32'd0;
      if (mem_en) begin
         val2 = {20'd0, shift_operand};
      end else if (imm) begin
         val2 = ror32({24'd0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
      end else begin
         case (shift_operand[6:5])
            2'b00:   val2 = val_rm << shift_operand[11:7];
            2'b01:   val2 = val_rm >> shift_operand[11:7];
            2'b10:   val2 = $unsigned($signed(val_rm) >>> shift_operand[11:7]);
            default: val2 = ror32(val_rm, shift_operand[11:7]);
         endcase
      end
   end
endmodule

module exe_alu (
   input  logic [31:0] val1,
   input  logic [31:0] val2,
   input  logic [3:0]  exe_cmd,
   input  logic [3:0]  sr,
   output logic [31:0] res,
   output logic [3:0]  nzcv
);
   logic [32:0] sum_s;
   logic        c_s;
   logic        v_s;

   // Logical ops keep the incoming C/V; arithmetic ops use ARM carry (C = no borrow on subtract)
   always_comb begin
      sum_s = 33'd0;
      c_s   = sr[1];
      v_s   = sr[0];
      case (exe_cmd)
         4'b0001: sum_s = {1'b0, val2};
         4'b1001: sum_s = {1'b0, ~val2};
         4'b0010, 4'b0011: begin
            sum_s = {1'b0, val1} + {1'b0, val2} + {32'd0, (exe_cmd[0] & sr[1])};
            c_s   = sum_s[32];
            v_s   = (val1[31] == val2[31]) && (sum_s[31] != val1[31]);
         end
         4'b0100, 4'b0101: begin
            sum_s = {1'b0, val1} - {1'b0, val2} - {32'd0, (exe_cmd[0] & ~sr[1])};
            c_s   = ~sum_s[32];
            v_s   = (val1[31] != val2[31]) && (sum_s[31] != val1[31]);
         end
         4'b0110: sum_s = {1'b0, val1 & val2};
         4'b0111: sum_s = {1'b0, val1 | val2};
         4'b1000: sum_s = {1'b0, val1 ^ val2};
         default: sum_s = 33'd0;
      endcase
      res  = sum_s[31:0];
      nzcv = {sum_s[31], (sum_s[31:0] == 32'd0), c_s, v_s};
   end
endmodule

module exe_stage_pipe #(
   parameter int NFWD    = 2,
   parameter int MUL_BPC = 1,
   parameter int SW      = $clog2(NFWD + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   input  logic                 WB_EN_IN,
   input  logic                 MEM_R_EN_IN,
   input  logic                 MEM_W_EN_IN,
   input  logic                 B_IN,
   input  logic                 S_IN,
   input  logic                 MUL_IN,
   input  logic                 ACC_IN,
   input  logic [3:0]           EXE_CMD_IN,
   input  logic [3:0]           SR_IN,
   input  logic [31:0]          PC_IN,
   input  logic [31:0]          VAL_RN_IN,
   input  logic [31:0]          VAL_RM_IN,
   input  logic [31:0]          VAL_RS_IN,
   input  logic                 IMM_IN,
   input  logic [11:0]          ShiftOperand_IN,
   input  logic [23:0]          Signed_IMM_24_IN,
   input  logic [3:0]           Dest_IN,
   input  logic [32*NFWD-1:0]   fwd_data,
   input  logic [SW-1:0]        sel_src1,
   input  logic [SW-1:0]        sel_src2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 WB_EN,
   output logic                 MEM_R_EN,
   output logic                 MEM_W_EN,
   output logic                 B,
   output logic                 S,
   output logic [31:0]          ALU_Res,
   output logic [31:0]          VAL_RM,
   output logic [3:0]           Dest,
   output logic [3:0]           Status,
   output logic [31:0]          Branch_Address,
   output logic                 busy
);
   localparam int L = 32 / MUL_BPC;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} mul_state_t;

   mul_state_t  state_r;
   logic [5:0]  count_r;
   logic [31:0] mcand_r;
   logic [31:0] mplier_r;
   logic [31:0] acc_r;
   logic [1:0]  mul_cv_r;
   logic [4:0]  mul_ctl_r;
   logic [3:0]  mul_dest_r;
   logic [31:0] mul_rm_r;
   logic [31:0] mul_br_r;

   logic [31:0] val1_s;
   logic [31:0] rm_s;
   logic [31:0] val2_s;
   logic [31:0] alu_res_s;
   logic [3:0]  alu_nzcv_s;
   logic [31:0] br_addr_s;
   logic [31:0] acc_next_s;
   logic        out_free_s;
   logic        accept_s;
   logic        alu_load_s;
   logic        mul_load_s;

   // Select values above NFWD fall back to the register file
   function automatic logic [31:0] fwd_mux(input logic [31:0] rf, input logic [32*NFWD-1:0] fwd,
                                           input logic [SW-1:0] sel);
      logic [31:0] v;
      v = rf;
      for (int k = 1; k <= NFWD; k++) begin
         if (int'(sel) == k) v = fwd[32*(k-1) +: 32];
         else v = v;
      end
      return v;
   endfunction

   assign out_free_s = !out_valid || out_ready;
   assign in_ready   = (state_r == IDLE) && out_free_s;
   assign accept_s   = in_valid && in_ready && !flush;
   assign alu_load_s = accept_s && !MUL_IN;
   assign mul_load_s = (state_r == DONE) && out_free_s;
   assign busy       = (state_r != IDLE);

   assign val1_s    = fwd_mux(VAL_RN_IN, fwd_data, sel_src1);
   assign rm_s      = fwd_mux(VAL_RM_IN, fwd_data, sel_src2);
   assign br_addr_s = PC_IN + {{6{Signed_IMM_24_IN[23]}}, Signed_IMM_24_IN, 2'b00};

   exe_val2gen u_val2gen (
      .val_rm        (rm_s),
      .imm           (IMM_IN),
      .shift_operand (ShiftOperand_IN),
      .mem_en        (MEM_R_EN_IN | MEM_W_EN_IN),
      .val2          (val2_s)
   );

   exe_alu u_alu (
      .val1    (val1_s),
      .val2    (val2_s),
      .exe_cmd (EXE_CMD_IN),
      .sr      (SR_IN),
      .res     (alu_res_s),
      .nzcv    (alu_nzcv_s)
   );

   // One multiplier step: add shifted multiplicand for each set low multiplier bit
   always_comb begin
      acc_next_s = acc_r;
      for (int i = 0; i < MUL_BPC; i++) begin
         if (mplier_r[i]) acc_next_s = acc_next_s + (mcand_r << i);
         else acc_next_s = acc_next_s;
      end
   end

   // Multiplier sequencer; the accumulator starts at the addend so DONE holds product + addend
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         count_r    <= 6'd0;
         mcand_r    <= 32'd0;
         mplier_r   <= 32'd0;
         acc_r      <= 32'd0;
         mul_cv_r   <= 2'd0;
         mul_ctl_r  <= 5'd0;
         mul_dest_r <= 4'd0;
         mul_rm_r   <= 32'd0;
         mul_br_r   <= 32'd0;
      end else if (flush) begin
         state_r <= IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s && MUL_IN) begin
                  state_r    <= RUN;
                  count_r    <= 6'(L);
                  mcand_r    <= val1_s;
                  mplier_r   <= rm_s;
                  acc_r      <= ACC_IN ? VAL_RS_IN : 32'd0;
                  mul_cv_r   <= SR_IN[1:0];
                  mul_ctl_r  <= {WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN};
                  mul_dest_r <= Dest_IN;
                  mul_rm_r   <= rm_s;
                  mul_br_r   <= br_addr_s;
               end
            end
            RUN: begin
               acc_r    <= acc_next_s;
               mcand_r  <= mcand_r << MUL_BPC;
               mplier_r <= mplier_r >> MUL_BPC;
               count_r  <= count_r - 6'd1;
               if (count_r == 6'd1) state_r <= DONE;
            end
            DONE: begin
               if (mul_load_s) state_r <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // EXE/MEM register: data holds while stalled, out_valid survives a same-cycle drain and load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid      <= 1'b0;
         WB_EN          <= 1'b0;
         MEM_R_EN       <= 1'b0;
         MEM_W_EN       <= 1'b0;
         B              <= 1'b0;
         S              <= 1'b0;
         ALU_Res        <= 32'd0;
         VAL_RM         <= 32'd0;
         Dest           <= 4'd0;
         Status         <= 4'd0;
         Branch_Address <= 32'd0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else begin
         if (alu_load_s) begin
            {WB_EN, MEM_R_EN, MEM_W_EN, B, S} <= {WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN};
            ALU_Res        <= alu_res_s;
            Status         <= alu_nzcv_s;
            VAL_RM         <= rm_s;
            Dest           <= Dest_IN;
            Branch_Address <= br_addr_s;
         end else if (mul_load_s) begin
            {WB_EN, MEM_R_EN, MEM_W_EN, B, S} <= mul_ctl_r;
            ALU_Res        <= acc_r;
            Status         <= {acc_r[31], (acc_r == 32'd0), mul_cv_r};
            VAL_RM         <= mul_rm_r;
            Dest           <= mul_dest_r;
            Branch_Address <= mul_br_r;
         end
         if (alu_load_s || mul_load_s) out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;
      end
   end
endmodule
